// File: rtl/matrix_mul.sv
`default_nettype none
// ============================================================================
// matrix_mul : pipelined signed matrix multiplier, RES = A x B (3-cycle latency)
// Rev 1.0
// ============================================================================
module matrix_mul #(
    parameter int BITS     = 8,
    parameter int WIDTH    = 3,
    parameter int HEIGHT_A = 2,
    parameter int WIDTH_B  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BITS-1:0]     i_array_a   [HEIGHT_A][WIDTH],
    input  logic [BITS-1:0]     i_array_b   [WIDTH][WIDTH_B],
    output logic [2*BITS-1:0]   o_array_res [HEIGHT_A][WIDTH_B]
);

    localparam int c_RW = 2 * BITS;

    logic [BITS-1:0] r_a    [HEIGHT_A][WIDTH];
    logic [BITS-1:0] r_b    [WIDTH][WIDTH_B];
    logic [c_RW-1:0] w_prod [HEIGHT_A][WIDTH_B][WIDTH];
    logic [c_RW-1:0] r_prod [HEIGHT_A][WIDTH_B][WIDTH];
    logic [c_RW-1:0] w_sum  [HEIGHT_A][WIDTH_B];

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HEIGHT_A; i++)
                for (int k = 0; k < WIDTH; k++)
                    r_a[i][k] <= '0;
            for (int k = 0; k < WIDTH; k++)
                for (int j = 0; j < WIDTH_B; j++)
                    r_b[k][j] <= '0;
        end else begin
            r_a <= i_array_a;
            r_b <= i_array_b;
        end
    end

    // Sign-extend to full width first so the truncated product is the exact
    // two's-complement result modulo 2^(2*BITS).
    always_comb begin
        for (int i = 0; i < HEIGHT_A; i++)
            for (int j = 0; j < WIDTH_B; j++)
                for (int k = 0; k < WIDTH; k++)
                    w_prod[i][j][k] = {{BITS{r_a[i][k][BITS-1]}}, r_a[i][k]}
                                    * {{BITS{r_b[k][j][BITS-1]}}, r_b[k][j]};
    end

    // Stage 2: product registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HEIGHT_A; i++)
                for (int j = 0; j < WIDTH_B; j++)
                    for (int k = 0; k < WIDTH; k++)
                        r_prod[i][j][k] <= '0;
        end else begin
            r_prod <= w_prod;
        end
    end

    always_comb begin
        for (int i = 0; i < HEIGHT_A; i++)
            for (int j = 0; j < WIDTH_B; j++) begin
                w_sum[i][j] = '0;
                for (int k = 0; k < WIDTH; k++)
                    w_sum[i][j] = w_sum[i][j] + r_prod[i][j][k];
            end
    end

    // Stage 3: result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HEIGHT_A; i++)
                for (int j = 0; j < WIDTH_B; j++)
                    o_array_res[i][j] <= '0;
        end else begin
            o_array_res <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mul.sv
`default_nettype none
// ============================================================================
// tb_matrix_mul : directed + random checks of matrix_mul against a queue model
// Rev 1.0
// ============================================================================
module tb_matrix_mul;

    typedef logic [7:0]  mat_a_t [2][3];
    typedef logic [7:0]  mat_b_t [3][3];
    typedef logic [15:0] res_t   [2][3];

    logic   clk = 1'b0;
    logic   reset;
    mat_a_t a;
    mat_b_t b;
    res_t   res;

    int   n_checks = 0;
    int   n_fails  = 0;
    res_t q[$];
    res_t cur_exp;
    res_t zero_res;

    matrix_mul #(.BITS(8), .WIDTH(3), .HEIGHT_A(2), .WIDTH_B(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_array_a   (a),
        .i_array_b   (b),
        .o_array_res (res)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input mat_a_t ma, input mat_b_t mb);
        res_t r;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'($signed(ma[i][k])) * int'($signed(mb[k][j]));
                r[i][j] = s[15:0];
            end
        return r;
    endfunction

    task automatic check(input string tag, input res_t exp);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                assert (res[i][j] === exp[i][j]) else begin
                    n_fails++;
                    $error("FAIL %s[%0d][%0d] observed %0h expected %0h",
                           tag, i, j, res[i][j], exp[i][j]);
                end
            end
    endtask

    // One rising edge: update the latency model, then compare 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) begin
            q.delete();
        end else begin
            q.push_back(model(a, b));
            if (q.size() > 3) void'(q.pop_front());
        end
        cur_exp = (q.size() == 3) ? q[0] : zero_res;
        #1;
        check(tag, cur_exp);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++)
                a[i][k] = 8'($urandom);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                b[k][j] = 8'($urandom);
    endtask

    mat_a_t pos_a, sgn_a, ovf_a;
    mat_b_t pos_b, ovf_b;
    res_t   pos_exp, sgn_exp, ovf_exp;

    initial begin
        pos_a   = '{'{8'd3, 8'd4, 8'd5}, '{8'd6, 8'd7, 8'd8}};
        pos_b   = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
        sgn_a   = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'hFB, 8'd0}};
        ovf_a   = '{'{8'h80, 8'h80, 8'h80}, '{8'h80, 8'h80, 8'h80}};
        ovf_b   = '{'{8'h80, 8'h80, 8'h80}, '{8'h80, 8'h80, 8'h80}, '{8'h80, 8'h80, 8'h80}};
        pos_exp = '{'{16'd54, 16'd66, 16'd78}, '{16'd90, 16'd111, 16'd132}};
        sgn_exp = '{'{16'd1, 16'd2, 16'd3}, '{16'hFFEC, 16'hFFE7, 16'hFFE2}};
        ovf_exp = '{'{16'hC000, 16'hC000, 16'hC000}, '{16'hC000, 16'hC000, 16'hC000}};
        zero_res = '{'{16'd0, 16'd0, 16'd0}, '{16'd0, 16'd0, 16'd0}};
        cur_exp  = zero_res;

        // Held in reset with arbitrary operands
        reset = 1'b0;
        randomize_ops();
        step("reset_hold");
        randomize_ops();
        step("reset_hold");
        step("reset_hold");

        // Latency/throughput: positive set then signed set back to back
        #3 reset = 1'b1;
        a = pos_a; b = pos_b;
        step("lat_e1");
        a = sgn_a;
        step("lat_e2");
        randomize_ops();
        step("lat_e3");
        check("pos_literal", pos_exp);
        randomize_ops();
        step("lat_e4");
        check("sgn_literal", sgn_exp);

        // Overflow wraps without saturation
        a = ovf_a; b = ovf_b;
        step("ovf");
        step("ovf");
        step("ovf");
        check("ovf_literal", ovf_exp);

        // Async reset mid-period with the positive set in flight
        a = pos_a; b = pos_b;
        step("pre_rst");
        step("pre_rst");
        #3 reset = 1'b0;
        q.delete();
        #1 check("async_rst", zero_res);
        step("rst_low");
        #3 reset = 1'b1;
        step("rel_e1");
        step("rel_e2");
        step("rel_e3");
        check("rel_literal", pos_exp);

        // Random operand stream, new set every cycle
        for (int n = 0; n < 40; n++) begin
            randomize_ops();
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
